m_trans_stream: RTL
===================

// Module: m_trans_stream
// PURPOSE
//  Parametrised successor to the per-digit M-transform array in the four-valued
//  multiplier datapath. Maps every 2-bit digit pair (a,b) of a P-digit operand to
//  a 2-bit digit m through a runtime-programmable 16-entry LUT.
//  Processes the operand L digits per cycle, so one lane set is shared across the word.
//  Valid/ready handshake on both sides; sits between operand staging and the partial-product adder.
// PARAMETERS
//  P        33            operand width in digits (a_i and m_o are 2*P bits)
//  L        4             digits processed per cycle, 1..P; NCHUNK = ceil(P/L)
//  LUT_RST  32'h5564_5546 LUT reset value; entry idx={a,b} lives at bits [2*idx+1:2*idx]
//                         (00,00)->10, (10,00)->00, (10,10)->10, (00,10)->00, all other pairs->01
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    synchronous active-low reset
//  in_valid   in   1    job offered
//  in_ready   out  1    job accepted when in_valid & in_ready
//  mode_i     in   1    0: broadcast b_i to all digits; 1: per-digit b from bv_i
//  a_i        in   2*P  operand A, digit k at [2k+1:2k]
//  b_i        in   2    broadcast B digit (mode 0)
//  bv_i       in   2*P  per-digit B (mode 1)
//  out_valid  out  1    result available
//  out_ready  in   1    result consumed when out_valid & out_ready
//  m_o        out  2*P  result digits, stable while out_valid
//  cfg_we     in   1    LUT write strobe
//  cfg_idx    in   4    LUT entry {a,b}
//  cfg_val    in   2    new entry value
//  cfg_rej    out  1    one-cycle pulse: cfg_we arrived while not IDLE, write dropped
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, in_ready=1 after reset, out_valid=0, m_o=0, cfg_rej=0.
//   - LUT=LUT_RST; chunk counter=0.
//  FSM: IDLE -> BUSY on in_valid & in_ready; BUSY -> DONE after NCHUNK cycles;
//   DONE -> IDLE on out_ready.
//  in_ready = (state==IDLE). It is combinational from state and never depends on in_valid.
//  Accept:
//   - Latch a_i into a shift register.
//   - Latch the effective B into a shift register: {P{b_i}} if mode_i=0, else bv_i.
//   - Clear the counter.
//  BUSY cycle c (c = 0..NCHUNK-1):
//   - Lanes j = 0..L-1 compute digit k = c*L+j as LUT[{a_k,b_k}].
//   - The result is written to m register digit k. Both shift registers shift by L digits.
//   - Last chunk with P%L != 0: only lanes with k < P write; pad lanes are discarded.
//  Latency: acceptance at edge t gives out_valid=1 after edge t+NCHUNK (P=33, L=4: 9 cycles).
//  DONE:
//   - out_valid=1; m_o and internal state are frozen until out_ready.
//   - The DONE->IDLE edge drops out_valid. A new job is accepted no earlier than the next cycle.
//   - Back-to-back throughput is 1 job per NCHUNK+2 cycles with out_ready held high.
//  m_o holds the last result through IDLE and is overwritten digit-by-digit during the next BUSY.
//  LUT config:
//   - cfg_we in IDLE writes LUT[cfg_idx]=cfg_val at that edge.
//   - cfg_we in BUSY/DONE is ignored and cfg_rej=1 the next cycle.
//   - The LUT is constant for the full duration of any job.
//  Simultaneous cfg_we and accept in IDLE:
//   - The write commits at the same edge as the accept.
//   - The job uses the NEW entry, because the first lookup occurs in BUSY.
//  The digit value 11 is legal input and maps through the LUT like any other pair.
//  Reset mid-job: the job is abandoned, no out_valid is produced, and the LUT returns to LUT_RST.
// STRUCTURE
//  m_trans_pkg:
//   - Digit constants Q_0=2'b00, Q_H=2'b01, Q_1=2'b10, Q_X=2'b11.
//   - LUT_RST default value.
//   - State enum {IDLE, BUSY, DONE}.
//   - Function nchunk(P,L).
//  Sub-module m_trans_lane: combinational, inputs (a[1:0], b[1:0], lut[31:0]), output m[1:0].
//   Instantiate L copies in a generate loop.
//  Top level holds the FSM, counter, shift registers, m register, LUT and config logic.
// TESTING
//  Default LUT and broadcast: P=33, L=4.
//   - Drive mode_i=0, b_i=00, a_i=all 00 -> m_o all 10, with out_valid exactly 9 cycles after accept.
//   - Drive b_i=00, a_i=all 10 -> m_o all 00.
//   - Drive a_i=alternating 01/11 -> m_o all 01.
//  Per-digit mode: drive digit k with a=10, b=(k even ? 10 : 00) -> m digit k = (k even ? 10 : 00).
//   Digit 32, in the partial last chunk, must be correct.
//  Back-pressure: hold out_ready=0 for 20 cycles in DONE.
//   - in_ready=0, out_valid=1 and m_o stable throughout.
//   - in_valid pulses during that window are not accepted.
//  LUT write: in IDLE write idx=0 -> 11, then run a=00,b=00 -> m all 11.
//   - cfg_we during BUSY -> cfg_rej pulse, and the next job still sees the previous LUT.
//  Reset mid-BUSY: assert rst_n=0 at chunk 4.
//   - out_valid=0, in_ready=1 after reset.
//   - LUT reads back as default: a=00,b=00 -> 10.
//  Sweep L in {1,4,33}: all 16 (a,b) pairs broadcast.
//   - Results match the LUT_RST table.
//   - Latency equals 33, 9 and 1 respectively.

Source files
------------

// File: rtl/m_trans_pkg.sv
// m_trans_pkg: shared digit encodings, default LUT, FSM states and chunk arithmetic for the M-transform stream
package m_trans_pkg;
    typedef logic [1:0] digit_t;
    localparam digit_t Q_0 = 2'b00;
    localparam digit_t Q_H = 2'b01;
    localparam digit_t Q_1 = 2'b10;
    localparam digit_t Q_X = 2'b11;
    // entry {a,b} sits at bits [2*idx+1:2*idx]; listed here from idx 15 down to idx 0
    localparam logic [31:0] LUT_RST_DEF = {
        Q_H, Q_H, Q_H, Q_H,
        Q_H, Q_1, Q_H, Q_0,
        Q_H, Q_H, Q_H, Q_H,
        Q_H, Q_0, Q_H, Q_1
    };
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;
    function automatic int nchunk(input int p, input int l);
        return (p + l - 1) / l;
    endfunction
endpackage

// File: rtl/m_trans_if.sv
// m_trans_if: job handshake, result and LUT configuration bundle for m_trans_stream
interface m_trans_if
    import m_trans_pkg::*;
#(
    parameter int P = 33
);
    logic           in_valid;
    logic           in_ready;
    logic           mode_i;
    logic [2*P-1:0] a_i;
    digit_t         b_i;
    logic [2*P-1:0] bv_i;
    logic           out_valid;
    logic           out_ready;
    logic [2*P-1:0] m_o;
    logic           cfg_we;
    logic [3:0]     cfg_idx;
    digit_t         cfg_val;
    logic           cfg_rej;
    modport master (
        output in_valid, mode_i, a_i, b_i, bv_i, out_ready, cfg_we, cfg_idx, cfg_val,
        input  in_ready, out_valid, m_o, cfg_rej
    );
    modport slave (
        input  in_valid, mode_i, a_i, b_i, bv_i, out_ready, cfg_we, cfg_idx, cfg_val,
        output in_ready, out_valid, m_o, cfg_rej
    );
endinterface

// File: rtl/m_trans_lane.sv
// m_trans_lane: one digit pair looked up in the 16-entry M-transform LUT
module m_trans_lane
    import m_trans_pkg::*;
(
    input  digit_t      a,
    input  digit_t      b,
    input  logic [31:0] lut,
    output digit_t      m
);
    assign m = lut[{a, b, 1'b0} +: 2];
endmodule

// File: rtl/m_trans_stream.sv
// m_trans_stream: maps a P-digit operand through a programmable LUT, L digits per cycle
module m_trans_stream
    import m_trans_pkg::*;
#(
    parameter int          P       = 33,
    parameter int          L       = 4,
    parameter logic [31:0] LUT_RST = LUT_RST_DEF
) (
    input logic      clk,
    input logic      rst_n,
    m_trans_if.slave bus
);
    localparam int NCHUNK = nchunk(P, L);
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [1:0] IDLE = 2'(S_IDLE);
    localparam logic [1:0] BUSY = 2'(S_BUSY);
    localparam logic [1:0] DONE = 2'(S_DONE);
    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [2*P-1:0]        a_sr;
    logic [2*P-1:0]        b_sr;
    logic [2*P-1:0]        m_r;
    logic [31:0]           lut;
    logic                  cfg_rej;
    logic [L-1:0][1:0]     lane_m;
    logic                  last;
    assign last          = cnt == CW'(NCHUNK - 1);
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.m_o       = m_r;
    assign bus.cfg_rej   = cfg_rej;
    for (genvar j = 0; j < L; j++) begin : g_lane
        m_trans_lane u_lane (
            .a   (a_sr[2*j +: 2]),
            .b   (b_sr[2*j +: 2]),
            .lut (lut),
            .m   (lane_m[j])
        );
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            m_r     <= '0;
            lut     <= LUT_RST;
            cfg_rej <= 1'b0;
        end else begin
            cfg_rej <= bus.cfg_we && state != IDLE;
            // LUT only changes in IDLE, so a job never sees it move under it
            if (bus.cfg_we && state == IDLE)
                lut[{bus.cfg_idx, 1'b0} +: 2] <= bus.cfg_val;
            if (state == IDLE && bus.in_valid) begin
                state <= BUSY;
                cnt   <= '0;
                a_sr  <= bus.a_i;
                b_sr  <= bus.mode_i ? bus.bv_i : {P{bus.b_i}};
            end else if (state == BUSY) begin
                for (int j = 0; j < L; j++)
                    if (int'(cnt) * L + j < P)
                        m_r[2*(int'(cnt) * L + j) +: 2] <= lane_m[j];
                a_sr  <= a_sr >> (2 * L);
                b_sr  <= b_sr >> (2 * L);
                cnt   <= cnt + CW'(1);
                state <= last ? DONE : BUSY;
            end else if (state == DONE && bus.out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule
